// File: rtl/note_player_pkg.sv
// Shared widths, FSM state type and the octave-0 half-period table for note_player.
package note_player_pkg;

  localparam int NOTE_BITS        = 3;
  localparam int OCTAVE_BITS      = 2;
  localparam int LENGTH_BITS      = 3;
  localparam int HALF_PERIOD_BITS = 19;

  localparam logic [NOTE_BITS-1:0] NOTE_REST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Octave-0 half-periods in 100 MHz cycles; rest has no pitch.
  function automatic logic [HALF_PERIOD_BITS-1:0] base_half(input logic [NOTE_BITS-1:0] note);
    case (note)
      3'd0:    return 19'd382234;
      3'd1:    return 19'd340530;
      3'd2:    return 19'd303379;
      3'd3:    return 19'd286352;
      3'd4:    return 19'd255102;
      3'd5:    return 19'd227273;
      3'd6:    return 19'd202478;
      default: return 19'd0;
    endcase
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Valid/ready note-event channel between the entry/playback stage and note_player.
interface note_player_if;
  import note_player_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [OCTAVE_BITS-1:0] in_octave;
  logic [NOTE_BITS-1:0]   in_note;
  logic [LENGTH_BITS-1:0] in_length;

  modport master (output in_valid, in_octave, in_note, in_length, input in_ready);
  modport slave  (input in_valid, in_octave, in_note, in_length, output in_ready);
endinterface

// File: rtl/note_period_rom.sv
// Combinational half-period lookup: table entry shifted by octave and DIV_SHIFT, clamped to >= 1.
module note_period_rom
  import note_player_pkg::*;
#(
  parameter int DIV_SHIFT = 0
) (
  input  logic [NOTE_BITS-1:0]        note,
  input  logic [OCTAVE_BITS-1:0]      octave,
  output logic [HALF_PERIOD_BITS-1:0] half
);
  logic [HALF_PERIOD_BITS-1:0] shifted;

  always_comb begin
    shifted = base_half(note) >> (int'(octave) + DIV_SHIFT);
    half    = (shifted == '0) ? {{(HALF_PERIOD_BITS-1){1'b0}}, 1'b1} : shifted;
  end
endmodule

// File: rtl/note_player.sv
// Plays one (octave, note, length) event as a square wave on buzzer, then an optional silent gap.
// Build option: define NOTE_PLAYER_GAP_EN to include the articulation gap (GAP state).
module note_player
  import note_player_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int UNIT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_000_000,
  parameter int DIV_SHIFT  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  note_player_if.slave  up,
  output logic          buzzer,
  output logic          busy,
  output logic          done
);
  localparam int DUR_BITS = $clog2(8 * UNIT_TICKS + 1);

  if (CLK_HZ < 1 || UNIT_TICKS < 1 || GAP_TICKS < 1) begin : g_cfg_check
    $error("note_player: CLK_HZ, UNIT_TICKS and GAP_TICKS must be positive");
  end

  state_t                       state_reg, state_next;
  logic [NOTE_BITS-1:0]         note_reg, note_next;
  logic [OCTAVE_BITS-1:0]       octave_reg, octave_next;
  logic [DUR_BITS-1:0]          dur_reg, dur_next;
  logic [DUR_BITS-1:0]          dur_last_reg, dur_last_next;
  logic [HALF_PERIOD_BITS-1:0]  phase_reg, phase_next;
  logic                         buzzer_reg, buzzer_next;
  logic                         done_reg, done_next;
  logic [HALF_PERIOD_BITS-1:0]  half;

`ifdef NOTE_PLAYER_GAP_EN
  localparam int GAP_BITS = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  logic [GAP_BITS-1:0] gap_reg, gap_next;
`endif

  note_period_rom #(.DIV_SHIFT(DIV_SHIFT)) u_rom (
    .note   (note_reg),
    .octave (octave_reg),
    .half   (half)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      note_reg     <= '0;
      octave_reg   <= '0;
      dur_reg      <= '0;
      dur_last_reg <= '0;
      phase_reg    <= '0;
      buzzer_reg   <= 1'b0;
      done_reg     <= 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
      gap_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      note_reg     <= note_next;
      octave_reg   <= octave_next;
      dur_reg      <= dur_next;
      dur_last_reg <= dur_last_next;
      phase_reg    <= phase_next;
      buzzer_reg   <= buzzer_next;
      done_reg     <= done_next;
`ifdef NOTE_PLAYER_GAP_EN
      gap_reg      <= gap_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    note_next     = note_reg;
    octave_next   = octave_reg;
    dur_next      = dur_reg;
    dur_last_next = dur_last_reg;
    phase_next    = phase_reg;
    buzzer_next   = buzzer_reg;
    done_next     = 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
    gap_next      = gap_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        buzzer_next = 1'b0;
        if (up.in_valid && en) begin
          note_next     = up.in_note;
          octave_next   = up.in_octave;
          dur_next      = '0;
          dur_last_next = DUR_BITS'((int'(up.in_length) + 1) * UNIT_TICKS - 1);
          phase_next    = '0;
          // First half-period is high for pitched notes.
          buzzer_next   = (up.in_note != NOTE_REST);
          state_next    = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (!en) begin
          state_next  = ST_IDLE;
          buzzer_next = 1'b0;
        end else if (dur_reg == dur_last_reg) begin
          buzzer_next = 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
          gap_next    = '0;
          state_next  = ST_GAP;
`else
          done_next   = 1'b1;
          state_next  = ST_IDLE;
`endif
        end else begin
          dur_next = dur_reg + 1'b1;
          if (phase_reg == half - 1'b1) begin
            phase_next  = '0;
            buzzer_next = (note_reg != NOTE_REST) && !buzzer_reg;
          end else begin
            phase_next = phase_reg + 1'b1;
          end
        end
      end

`ifdef NOTE_PLAYER_GAP_EN
      ST_GAP: begin
        buzzer_next = 1'b0;
        if (!en) begin
          state_next = ST_IDLE;
        end else if (gap_reg == GAP_BITS'(GAP_TICKS - 1)) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
`endif

      default: begin
        state_next  = ST_IDLE;
        buzzer_next = 1'b0;
      end
    endcase
  end

  assign up.in_ready = (state_reg == ST_IDLE) && en;
  assign busy        = (state_reg != ST_IDLE);
  assign buzzer      = buzzer_reg;
  assign done        = done_reg;
endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player against a cycle-indexed waveform model.
module tb_note_player;
  localparam int UNIT = 100;
  localparam int GAP  = 10;
  localparam int DIVS = 10;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int GAP_EXP = GAP;
`else
  localparam int GAP_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic buzzer, busy, done;
  int   checks = 0;
  int   failures = 0;
  int   base_tab [7] = '{382234, 340530, 303379, 286352, 255102, 227273, 202478};

  note_player_if bus();

  note_player #(.CLK_HZ(100_000_000), .UNIT_TICKS(UNIT), .GAP_TICKS(GAP), .DIV_SHIFT(DIVS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .up     (bus.slave),
    .buzzer (buzzer),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_half(input int note, input int oct);
    int h;
    if (note > 6) return 1;
    h = base_tab[note] / (1 << (oct + DIVS));
    return (h == 0) ? 1 : h;
  endfunction

  // Expected buzzer in relative PLAY cycle t (1-based).
  function automatic bit exp_buzz(input int note, input int oct, input int len, input int t);
    if (note == 7 || t < 1 || t > (len + 1) * UNIT) return 1'b0;
    return ((t - 1) / exp_half(note, oct)) % 2 == 0;
  endfunction

  task automatic offer(input int oct, input int note, input int len);
    bus.in_octave = 2'(oct);
    bus.in_note   = 3'(note);
    bus.in_length = 3'(len);
    bus.in_valid  = 1'b1;
  endtask

  // Called in the first PLAY cycle; returns in the done cycle.
  task automatic check_note(input int oct, input int note, input int len, output int toggles);
    int  n;
    bit  eb;
    logic prev;
    n = (len + 1) * UNIT;
    toggles = 0;
    prev = buzzer;
    for (int t = 1; t <= n + GAP_EXP; t++) begin
      eb = exp_buzz(note, oct, len, t);
      if (t > 1 && t <= n && buzzer !== prev) toggles++;
      prev = buzzer;
      checks++;
      if (buzzer !== eb || busy !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL note o%0d n%0d l%0d t=%0d buzzer=%b exp=%b busy=%b exp=1 done=%b exp=0 ready=%b exp=0",
                 oct, note, len, t, buzzer, eb, busy, done, bus.in_ready);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || buzzer !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_cycle o%0d n%0d l%0d done=%b exp=1 busy=%b exp=0 buzzer=%b exp=0 ready=%b exp=1",
               oct, note, len, done, busy, buzzer, bus.in_ready);
    end
  endtask

  task automatic play(input int oct, input int note, input int len, output int toggles);
    offer(oct, note, len);
    tick();
    bus.in_valid = 1'b0;
    check_note(oct, note, len, toggles);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done done=%b exp=0 busy=%b exp=0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    bus.in_valid = 1'b0; bus.in_octave = '0; bus.in_note = '0; bus.in_length = '0;
    #1;
    checks++;
    if (buzzer !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset buzzer=%b busy=%b done=%b ready=%b exp all 0", buzzer, busy, done, bus.in_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_en_low ready=%b exp=0", bus.in_ready);
    end
    en = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_en_high ready=%b exp=1 busy=%b exp=0", bus.in_ready, busy);
    end
    tick();
  endtask

  task automatic test_directed();
    int tg;
    play(0, 5, 0, tg);
    checks++;
    if (tg !== 0) begin
      failures++;
      $display("FAIL toggles_a0 got=%0d exp=0", tg);
    end
    play(1, 5, 1, tg);
    checks++;
    if (tg !== 1) begin
      failures++;
      $display("FAIL toggles_a1 got=%0d exp=1", tg);
    end
  endtask

  task automatic test_rest();
    int tg;
    play(2, 7, 3, tg);
    checks++;
    if (tg !== 0) begin
      failures++;
      $display("FAIL toggles_rest got=%0d exp=0", tg);
    end
  endtask

  task automatic test_random();
    int tg, o, n, l;
    for (int i = 0; i < 8; i++) begin
      o = $urandom_range(3, 0);
      n = $urandom_range(7, 0);
      l = $urandom_range(3, 0);
      play(o, n, l, tg);
      $display("random event %0d: octave=%0d note=%0d length=%0d toggles=%0d", i, o, n, l, tg);
    end
  endtask

  task automatic test_back_to_back();
    int tg;
    offer(3, 0, 0);
    tick();
    offer(1, 6, 1);  // second event held until in_ready
    check_note(3, 0, 0, tg);
    tick();
    bus.in_valid = 1'b0;
    check_note(1, 6, 1, tg);
    tick();
  endtask

  task automatic test_abort();
    bit eb;
    offer(1, 5, 1);
    tick();
    bus.in_valid = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      eb = exp_buzz(5, 1, 1, t);
      checks++;
      if (buzzer !== eb || busy !== 1'b1) begin
        failures++;
        $display("FAIL abort_play t=%0d buzzer=%b exp=%b busy=%b exp=1", t, buzzer, eb, busy);
      end
      tick();
    end
    en = 1'b0;
    tick();
    for (int t = 0; t < 20; t++) begin
      checks++;
      if (busy !== 1'b0 || buzzer !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle t=%0d busy=%b buzzer=%b done=%b ready=%b exp all 0",
                 t, busy, buzzer, done, bus.in_ready);
      end
      tick();
    end
    en = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_ready ready=%b exp=1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_reset_midplay();
    offer(0, 2, 2);
    tick();
    bus.in_valid = 1'b0;
    repeat (30) tick();
    checks++;
    if (busy !== 1'b1 || buzzer !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset busy=%b exp=1 buzzer=%b exp=1", busy, buzzer);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (buzzer !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset buzzer=%b busy=%b done=%b exp all 0", buzzer, busy, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset busy=%b exp=0 ready=%b exp=1", busy, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rest();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_midplay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
